// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_OUT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: single outstanding imem request, registered insn/pc/valid_insn to decode.
// Latency: word is presented the cycle after imem_ack; peak rate one word per 2 cycles.
// Backpressure: stall holds the presented word and defers new requests; redirect overrides stall.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid_insn,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         squash_q, squash_d;
    logic         req_d;
    logic [31:0]  addr_d;
    logic [31:0]  insn_d;
    logic [31:0]  pc_d;
    logic         valid_d;
    logic         err_d;
    logic [31:0]  count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            fetch_pc_q  <= RESET_PC;
            squash_q    <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            insn        <= 32'd0;
            pc          <= 32'd0;
            valid_insn  <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            squash_q    <= squash_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            insn        <= insn_d;
            pc          <= pc_d;
            valid_insn  <= valid_d;
            fetch_err   <= err_d;
            fetch_count <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        squash_d   = squash_q;
        req_d      = imem_req;
        addr_d     = imem_addr;
        insn_d     = insn;
        pc_d       = pc;
        valid_d    = valid_insn;
        err_d      = fetch_err;
        count_d    = fetch_count;

        if (redirect) begin
            fetch_pc_d = align_word(redirect_pc);
            valid_d    = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
            // An in-flight request cannot be cancelled: keep it up and drop its data later.
            if (state_q == FS_WAIT && !imem_ack) begin
                squash_d = 1'b1;
            end else begin
                state_d  = FS_IDLE;
                req_d    = 1'b0;
                squash_d = 1'b0;
            end
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (!stall) begin
                        state_d = FS_WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                FS_WAIT: begin
                    if (imem_ack) begin
                        req_d = 1'b0;
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = FS_IDLE;
                        end else begin
                            insn_d     = imem_rdata;
                            pc_d       = fetch_pc_q;
                            valid_d    = 1'b1;
                            fetch_pc_d = fetch_pc_q + PC_STEP;
                            state_d    = FS_OUT;
                        end
                    end
                end
                FS_OUT: begin
                    if (!stall) begin
                        count_d = fetch_count + 32'd1;
                        valid_d = 1'b0;
                        state_d = FS_WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = FS_IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem responder, consumed-word scoreboard, redirect vector table.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid_insn;
    logic        fetch_err;
    logic [31:0] fetch_count;

    logic        mem_en = 1'b1;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    int          mem_delay = 1;
    int          wcnt = 0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        err;
    } redir_vec_t;
    redir_vec_t vecs[3];

    assign imem_ack   = mem_ack | man_ack;
    assign imem_rdata = man_ack ? man_rdata : mem_rdata;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .insn        (insn),
        .pc          (pc),
        .valid_insn  (valid_insn),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory answers a raised request after mem_delay cycles with a one-cycle strobe.
    always @(negedge clk) begin
        if (!mem_en || !imem_req || mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (wcnt >= mem_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = word_of(imem_addr);
        end else begin
            wcnt = wcnt + 1;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; a word counts as consumed when presented with no stall and no redirect.
    task automatic step();
        logic        cons;
        logic [31:0] cpc, cinsn, e;
        cons  = valid_insn && !stall && !redirect && !rst;
        cpc   = pc;
        cinsn = insn;
        @(posedge clk);
        @(negedge clk);
        #1;
        if (cons) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL consume: unexpected word pc=%h insn=%h", cpc, cinsn);
            end else begin
                e = exp_q.pop_front();
                check32("consume_pc", cpc, e);
                check32("consume_insn", cinsn, word_of(e));
            end
        end
    endtask

    task automatic wait_consumed(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check32(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check32({tag, "_req"},   {31'd0, imem_req},   32'd0);
        check32({tag, "_addr"},  imem_addr,           RESET_PC_DEFAULT);
        check32({tag, "_insn"},  insn,                32'd0);
        check32({tag, "_pc"},    pc,                  32'd0);
        check32({tag, "_valid"}, {31'd0, valid_insn}, 32'd0);
        check32({tag, "_err"},   {31'd0, fetch_err},  32'd0);
        check32({tag, "_count"}, fetch_count,         32'd0);
    endtask

    initial begin
        int   n;
        logic stale;

        vecs[0] = '{rpc: 32'h0040_0013, addr: 32'h0040_0010, err: 1'b1};
        vecs[1] = '{rpc: 32'h0040_0020, addr: 32'h0040_0020, err: 1'b1};
        vecs[2] = '{rpc: 32'hFFFF_FFFC, addr: 32'hFFFF_FFFC, err: 1'b1};

        @(negedge clk);
        #1;
        check_reset_state("reset");

        // Sequential fetch, ack one cycle after each request.
        rst = 1'b0;
        exp_q.push_back(32'h8002_0000);
        exp_q.push_back(32'h8002_0004);
        exp_q.push_back(32'h8002_0008);
        n = 0;
        while (fetch_count != 32'd3 && n < 60) begin
            step();
            n++;
        end
        stall = 1'b1;
        check32("seq_count", fetch_count, 32'd3);
        check32("seq_drained", exp_q.size(), 32'd0);

        // Stall holds the presented word with no new request and no count.
        exp_q.push_back(32'h8002_000C);
        n = 0;
        while (!valid_insn && n < 20) begin
            step();
            n++;
        end
        check32("stall_valid", {31'd0, valid_insn}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check32("stall_pc", pc, 32'h8002_000C);
            check32("stall_insn", insn, word_of(32'h8002_000C));
            check32("stall_req", {31'd0, imem_req}, 32'd0);
            check32("stall_count", fetch_count, 32'd3);
        end
        mem_delay = 3;
        stall = 1'b0;
        step();
        check32("release_count", fetch_count, 32'd4);
        check32("release_req", {31'd0, imem_req}, 32'd1);
        check32("release_addr", imem_addr, 32'h8002_0010);
        check32("release_valid", {31'd0, valid_insn}, 32'd0);

        // Redirect during an outstanding request: stale word dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0010;
        step();
        redirect = 1'b0;
        check32("squash_req_held", {31'd0, imem_req}, 32'd1);
        check32("squash_addr_held", imem_addr, 32'h8002_0010);
        stale = 1'b0;
        n = 0;
        while (!(imem_req && imem_addr == 32'h0040_0010) && n < 20) begin
            step();
            if (valid_insn) stale = 1'b1;
            n++;
        end
        check32("squash_no_stale", {31'd0, stale}, 32'd0);
        check32("squash_next_addr", imem_addr, 32'h0040_0010);
        mem_delay = 2;
        exp_q.push_back(32'h0040_0010);
        wait_consumed("squash_target_timeout", 20);
        check32("squash_count", fetch_count, 32'd5);

        // Redirect coinciding with ack, then redirect under stall in OUT.
        n = 0;
        while (!mem_ack && n < 10) begin
            step();
            n++;
        end
        check32("coinc_ack_seen", {31'd0, mem_ack}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0100;
        step();
        redirect = 1'b0;
        check32("coinc_valid", {31'd0, valid_insn}, 32'd0);
        check32("coinc_req", {31'd0, imem_req}, 32'd0);
        check32("coinc_count", fetch_count, 32'd5);
        n = 0;
        while (!valid_insn && n < 20) begin
            step();
            n++;
        end
        stall = 1'b1;
        check32("coinc_target_pc", pc, 32'h0040_0100);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0200;
        step();
        redirect = 1'b0;
        check32("out_redir_valid", {31'd0, valid_insn}, 32'd0);
        check32("out_redir_count", fetch_count, 32'd5);
        step();
        step();
        check32("out_redir_idle_req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        exp_q.push_back(32'h0040_0200);
        wait_consumed("out_redir_timeout", 20);
        check32("out_redir_count2", fetch_count, 32'd6);

        // Redirect alignment and sticky error vectors.
        mem_delay = 0;
        for (int v = 0; v < 3; v++) begin
            stall       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = vecs[v].rpc;
            step();
            redirect = 1'b0;
            n = 0;
            while ((imem_req || valid_insn) && n < 20) begin
                step();
                n++;
            end
            stall = 1'b0;
            step();
            check32("vec_req", {31'd0, imem_req}, 32'd1);
            check32("vec_addr", imem_addr, vecs[v].addr);
            check32("vec_err", {31'd0, fetch_err}, {31'd0, vecs[v].err});
        end

        // PC wraps from FFFFFFFC to 0.
        exp_q.push_back(32'hFFFF_FFFC);
        mem_delay = 5;
        n = 0;
        while (!(imem_req && imem_addr == 32'd0) && n < 20) begin
            step();
            n++;
        end
        check32("wrap_addr", imem_addr, 32'd0);
        check32("wrap_consumed", exp_q.size(), 32'd0);
        check32("wrap_count", fetch_count, 32'd7);

        // Reset mid-request; an ack arriving afterwards is ignored.
        mem_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        step();
        rst       = 1'b0;
        man_ack   = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        step();
        man_ack = 1'b0;
        check32("late_ack_valid", {31'd0, valid_insn}, 32'd0);
        check32("late_ack_insn", insn, 32'd0);
        check32("late_ack_req", {31'd0, imem_req}, 32'd1);
        check32("late_ack_addr", imem_addr, RESET_PC_DEFAULT);
        mem_en    = 1'b1;
        mem_delay = 1;
        exp_q.push_back(RESET_PC_DEFAULT);
        wait_consumed("restart_timeout", 20);
        check32("restart_count", fetch_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
